gpmc_reg_arbiter: RTL and testbench

- Owns the GPMC-mapped register bank (direction/output/input words) and shares it between two requesters.
- Host requester: GPMC strobes from gpmc_sync (cs/we/oe active-low).
- Fabric requester: internal logic such as GPIO input samplers and counters, using a req/gnt handshake.
- Serialises at most one bank access per clk, enforces host write-protect on read-only words, bounds fabric starvation, and exports the whole bank flat to the gpio_port instances.

---
 rtl/gpmc_regs_pkg.sv | 12 +
 rtl/gpmc_strobe_capture.sv | 38 +++
 rtl/gpmc_reg_arbiter.sv | 103 ++++++++++
 tb/tb_gpmc_reg_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpmc_regs_pkg.sv
// gpmc_regs_pkg: shared widths, write-protect default and access types for the GPMC register bank
package gpmc_regs_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam logic [(1<<ADDR_W)-1:0] RO_MASK_DEF = 16'h0030;
  typedef enum logic [1:0] {ACC_NONE, ACC_HOST, ACC_FAB} acc_src_t;
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;
endpackage

// File: rtl/gpmc_strobe_capture.sv
// gpmc_strobe_capture: turns each host strobe assertion into one pending access, flagging overwrites
module gpmc_strobe_capture
  import gpmc_regs_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n_i,
  input  logic              we_n_i,
  input  logic              oe_n_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              grant_i,
  output logic              pend_o,
  output acc_t              acc_o,
  output logic              ovf_o
);
  logic act, act_edge, act_q, pend_q, ovf_q;
  acc_t acc_q;
  // both strobes low together is not a valid access
  assign act      = !cs_n_i & (!we_n_i ^ !oe_n_i);
  assign act_edge = act & !act_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q  <= 1'b0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
      acc_q  <= '0;
    end else begin
      act_q  <= act;
      pend_q <= act_edge | (pend_q & !grant_i);
      ovf_q  <= act_edge & pend_q & !grant_i;
      if (act_edge) acc_q <= '{we: !we_n_i, addr: addr_i, wdata: wdata_i};
    end
  end
  assign pend_o = pend_q;
  assign acc_o  = acc_q;
  assign ovf_o  = ovf_q;
endmodule

// File: rtl/gpmc_reg_arbiter.sv
// gpmc_reg_arbiter: register bank shared between GPMC host and fabric, one access per clk
// with host write-protect and a bounded host streak so a waiting fabric request is not starved.
module gpmc_reg_arbiter
  import gpmc_regs_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter logic [(1<<ADDR_WIDTH)-1:0] RO_MASK = RO_MASK_DEF,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                host_cs,
  input  logic                                host_we,
  input  logic                                host_oe,
  input  logic [ADDR_WIDTH-1:0]               host_addr,
  input  logic [DATA_WIDTH-1:0]               host_wdata,
  output logic [DATA_WIDTH-1:0]               host_rdata,
  output logic                                host_rvalid,
  output logic                                host_wr_drop,
  output logic                                host_ovf,
  input  logic                                fab_req,
  input  logic                                fab_we,
  input  logic [ADDR_WIDTH-1:0]               fab_addr,
  input  logic [DATA_WIDTH-1:0]               fab_wdata,
  output logic                                fab_gnt,
  output logic [DATA_WIDTH-1:0]               fab_rdata,
  output logic                                fab_rvalid,
  output logic [(1<<ADDR_WIDTH)*DATA_WIDTH-1:0] regs_flat
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] host_rdata_q, fab_rdata_q, wr_data;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [SW-1:0]         streak_q, streak_d;
  logic                  host_rvalid_q, host_wr_drop_q, fab_rvalid_q;
  logic                  host_pend, host_rd, host_wr, fab_rd, wr_en;
  acc_t                  host_acc;
  acc_src_t              src;

  gpmc_strobe_capture u_cap (
    .clk     (clk),
    .rst_n   (rst_n),
    .cs_n_i  (host_cs),
    .we_n_i  (host_we),
    .oe_n_i  (host_oe),
    .addr_i  (host_addr),
    .wdata_i (host_wdata),
    .grant_i (src == ACC_HOST),
    .pend_o  (host_pend),
    .acc_o   (host_acc),
    .ovf_o   (host_ovf)
  );

  // reset also masks the grant so a held fab_req sees no gnt while in reset
  always_comb begin
    src      = !rst_n ? ACC_NONE
             : (host_pend & !(fab_req & streak_q == LIM)) ? ACC_HOST
             : fab_req ? ACC_FAB : ACC_NONE;
    host_rd  = src == ACC_HOST & !host_acc.we;
    host_wr  = src == ACC_HOST & host_acc.we;
    fab_rd   = src == ACC_FAB & !fab_we;
    wr_en    = (host_wr & !RO_MASK[host_acc.addr]) | (src == ACC_FAB & fab_we);
    wr_addr  = src == ACC_HOST ? host_acc.addr : fab_addr;
    wr_data  = src == ACC_HOST ? host_acc.wdata : fab_wdata;
    streak_d = (!fab_req | src == ACC_FAB) ? '0
             : (src == ACC_HOST & streak_q != LIM) ? streak_q + 1'b1 : streak_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q         <= '{default: '0};
      host_rdata_q   <= '0;
      fab_rdata_q    <= '0;
      host_rvalid_q  <= 1'b0;
      host_wr_drop_q <= 1'b0;
      fab_rvalid_q   <= 1'b0;
      streak_q       <= '0;
    end else begin
      streak_q       <= streak_d;
      host_rvalid_q  <= host_rd;
      host_wr_drop_q <= host_wr & RO_MASK[host_acc.addr];
      fab_rvalid_q   <= fab_rd;
      if (host_rd) host_rdata_q <= regs_q[host_acc.addr];
      if (fab_rd) fab_rdata_q <= regs_q[fab_addr];
      if (wr_en) regs_q[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

  assign fab_gnt      = src == ACC_FAB;
  assign host_rdata   = host_rdata_q;
  assign host_rvalid  = host_rvalid_q;
  assign host_wr_drop = host_wr_drop_q;
  assign fab_rdata    = fab_rdata_q;
  assign fab_rvalid   = fab_rvalid_q;
endmodule

// File: tb/tb_gpmc_reg_arbiter.sv
// tb_gpmc_reg_arbiter: two arbiters (default streak limit and limit 0, which starves the host
// while fab_req is held) driven in parallel and compared against a behavioural model.
module tb_gpmc_reg_arbiter;
  logic clk = 0, rst_n = 0;
  logic host_cs = 1, host_we = 1, host_oe = 1, fab_req = 0, fab_we = 0;
  logic [3:0] host_addr = 0, fab_addr = 0;
  logic [15:0] host_wdata = 0, fab_wdata = 0;
  logic [15:0] h_rdata [2], f_rdata [2];
  logic h_rv [2], drop [2], ovf [2], gnt [2], f_rv [2];
  logic [255:0] flat [2];

  gpmc_reg_arbiter u_dut (
    .clk(clk), .rst_n(rst_n), .host_cs(host_cs), .host_we(host_we), .host_oe(host_oe),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(h_rdata[0]), .host_rvalid(h_rv[0]),
    .host_wr_drop(drop[0]), .host_ovf(ovf[0]), .fab_req(fab_req), .fab_we(fab_we),
    .fab_addr(fab_addr), .fab_wdata(fab_wdata), .fab_gnt(gnt[0]), .fab_rdata(f_rdata[0]),
    .fab_rvalid(f_rv[0]), .regs_flat(flat[0]));

  gpmc_reg_arbiter #(.STARVE_LIMIT(0)) u_dut_fp (
    .clk(clk), .rst_n(rst_n), .host_cs(host_cs), .host_we(host_we), .host_oe(host_oe),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(h_rdata[1]), .host_rvalid(h_rv[1]),
    .host_wr_drop(drop[1]), .host_ovf(ovf[1]), .fab_req(fab_req), .fab_we(fab_we),
    .fab_addr(fab_addr), .fab_wdata(fab_wdata), .fab_gnt(gnt[1]), .fab_rdata(f_rdata[1]),
    .fab_rvalid(f_rv[1]), .regs_flat(flat[1]));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int lim [2] = '{3, 0};
  localparam logic [15:0] RO = 16'h0030;
  bit m_pend [2], m_pwe [2], e_rv [2], e_drop [2], e_ovf [2], e_frv [2], act_prev;
  int m_paddr [2], m_pdata [2], m_streak [2], e_rdata [2], e_frdata [2];
  int bank [2][16];

  function automatic bit host_win(int k);
    return m_pend[k] && !(fab_req && m_streak[k] == lim[k]);
  endfunction

  function automatic bit exp_gnt(int k);
    return fab_req && !host_win(k);
  endfunction

  function automatic logic [255:0] exp_flat(int k);
    logic [255:0] v;
    for (int j = 0; j < 16; j++) v[j*16 +: 16] = bank[k][j][15:0];
    return v;
  endfunction

  task automatic model_reset();
    act_prev = 0;
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 0; m_pwe[k] = 0; m_paddr[k] = 0; m_pdata[k] = 0; m_streak[k] = 0;
      e_rv[k] = 0; e_drop[k] = 0; e_ovf[k] = 0; e_frv[k] = 0; e_rdata[k] = 0; e_frdata[k] = 0;
      for (int j = 0; j < 16; j++) bank[k][j] = 0;
    end
  endtask

  // advance one clock; model applies the grant/capture rules at the edge
  task automatic step();
    bit hg [2], fg [2];
    bit act, act_edge;
    act = !host_cs && ((!host_we) ^ (!host_oe));
    act_edge = act && !act_prev;
    for (int k = 0; k < 2; k++) begin
      hg[k] = host_win(k);
      fg[k] = exp_gnt(k);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      e_rv[k] = 0; e_drop[k] = 0; e_ovf[k] = 0; e_frv[k] = 0;
      if (hg[k]) begin
        if (!m_pwe[k]) begin e_rdata[k] = bank[k][m_paddr[k]]; e_rv[k] = 1; end
        else if (RO[m_paddr[k]]) e_drop[k] = 1;
        else bank[k][m_paddr[k]] = m_pdata[k];
        m_pend[k] = 0;
      end
      if (fg[k]) begin
        if (fab_we) bank[k][fab_addr] = fab_wdata;
        else begin e_frdata[k] = bank[k][fab_addr]; e_frv[k] = 1; end
      end
      m_streak[k] = (!fab_req || fg[k]) ? 0 : (hg[k] && m_streak[k] < lim[k]) ? m_streak[k] + 1 : m_streak[k];
      if (act_edge) begin
        if (m_pend[k]) e_ovf[k] = 1;
        m_pend[k] = 1; m_pwe[k] = !host_we; m_paddr[k] = host_addr; m_pdata[k] = host_wdata;
      end
    end
    act_prev = act;
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks += 4;
      if (flat[k] !== '0) begin failures++; $display("FAIL reset_flat k=%0d got=%h exp=0", k, flat[k]); end
      if (h_rv[k] !== 0 || f_rv[k] !== 0) begin failures++; $display("FAIL reset_rvalid k=%0d got=%b%b exp=00", k, h_rv[k], f_rv[k]); end
      if (h_rdata[k] !== 0 || f_rdata[k] !== 0) begin failures++; $display("FAIL reset_rdata k=%0d got=%h/%h exp=0", k, h_rdata[k], f_rdata[k]); end
      if (drop[k] !== 0 || ovf[k] !== 0 || gnt[k] !== 0) begin failures++; $display("FAIL reset_pulses k=%0d got=%b%b%b exp=000", k, drop[k], ovf[k], gnt[k]); end
    end
    rst_n = 1;
  endtask

  task automatic test_host_write();
    host_cs = 0; host_we = 0; host_oe = 1; host_addr = 0; host_wdata = 16'hA5A5;
    for (int i = 0; i < 4; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks += 2;
        if (flat[k][15:0] !== ((i == 0) ? 16'h0 : 16'hA5A5)) begin failures++; $display("FAIL host_wr_word0 k=%0d cyc=%0d got=%h exp=%h", k, i, flat[k][15:0], (i == 0) ? 16'h0 : 16'hA5A5); end
        if (flat[k] !== exp_flat(k)) begin failures++; $display("FAIL host_wr_flat k=%0d got=%h exp=%h", k, flat[k], exp_flat(k)); end
      end
    end
    host_cs = 1; host_we = 1;
    step();
  endtask

  task automatic test_ro_write();
    int drops = 0;
    host_cs = 0; host_we = 0; host_addr = 4; host_wdata = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin host_cs = 1; host_we = 1; end
      step();
      drops += int'(drop[0]);
      checks++;
      if (flat[0][64 +: 16] !== 16'h0) begin failures++; $display("FAIL ro_word4 cyc=%0d got=%h exp=0", i, flat[0][64 +: 16]); end
    end
    checks++;
    if (drops != 1) begin failures++; $display("FAIL ro_drop_count got=%0d exp=1", drops); end
    fab_req = 1; fab_we = 1; fab_addr = 4; fab_wdata = 16'h1234;
    #1;
    checks++;
    if (gnt[0] !== 1'b1) begin failures++; $display("FAIL ro_fab_gnt got=%b exp=1", gnt[0]); end
    step();
    fab_req = 0;
    checks++;
    if (flat[0][64 +: 16] !== 16'h1234) begin failures++; $display("FAIL ro_fab_write got=%h exp=1234", flat[0][64 +: 16]); end
  endtask

  task automatic test_host_read();
    int rvs = 0;
    host_cs = 0; host_oe = 0; host_we = 1; host_addr = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin host_cs = 1; host_oe = 1; end
      step();
      rvs += int'(h_rv[0]);
      checks++;
      if (h_rv[0] !== (i == 1)) begin failures++; $display("FAIL rd_rvalid cyc=%0d got=%b exp=%b", i, h_rv[0], i == 1); end
      if (i >= 1) begin
        checks++;
        if (h_rdata[0] !== 16'hA5A5) begin failures++; $display("FAIL rd_data cyc=%0d got=%h exp=a5a5", i, h_rdata[0]); end
      end
    end
    checks++;
    if (rvs != 1) begin failures++; $display("FAIL rd_rvalid_count got=%0d exp=1", rvs); end
  endtask

  task automatic test_back_to_back();
    int run = 0, max_run = 0, fgn = 0;
    bit g;
    logic [15:0] v;
    v = 16'($urandom_range(1, 16'hFFFF));
    fab_req = 1; fab_we = 1; fab_addr = 5; fab_wdata = v;
    for (int i = 0; i < 16; i++) begin
      host_cs = i[0]; host_we = i[0]; host_oe = 1; host_addr = 4'(i % 4); host_wdata = 16'($urandom);
      #1;
      g = exp_gnt(0);
      run = host_win(0) ? run + 1 : 0;
      if (run > max_run) max_run = run;
      checks++;
      if (gnt[0] !== g) begin failures++; $display("FAIL b2b_gnt cyc=%0d got=%b exp=%b", i, gnt[0], g); end
      step();
      if (g) begin fgn++; fab_we = 0; end
      if (f_rv[0]) begin
        checks++;
        if (f_rdata[0] !== v) begin failures++; $display("FAIL b2b_fab_rd5 got=%h exp=%h", f_rdata[0], v); end
      end
      checks++;
      if (flat[0] !== exp_flat(0)) begin failures++; $display("FAIL b2b_flat got=%h exp=%h", flat[0], exp_flat(0)); end
    end
    fab_req = 0; host_cs = 1; host_we = 1;
    step();
    checks += 2;
    if (max_run > 3) begin failures++; $display("FAIL b2b_streak got=%0d exp<=3", max_run); end
    if (fgn < 2) begin failures++; $display("FAIL b2b_fab_grants got=%0d exp>=2", fgn); end
  endtask

  task automatic test_ovf();
    int ovfs [2] = '{0, 0};
    fab_req = 1; fab_we = 0; fab_addr = 0;
    for (int i = 0; i < 8; i++) begin
      host_cs = !(i == 1 || i == 3); host_we = host_cs; host_oe = 1; host_addr = 2;
      host_wdata = (i < 3) ? 16'h1111 : 16'h2222;
      if (i == 5) fab_req = 0;
      step();
      for (int k = 0; k < 2; k++) begin
        ovfs[k] += int'(ovf[k]);
        checks++;
        if (ovf[k] !== e_ovf[k]) begin failures++; $display("FAIL ovf_pulse k=%0d cyc=%0d got=%b exp=%b", k, i, ovf[k], e_ovf[k]); end
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks += 2;
      if (ovfs[k] != k) begin failures++; $display("FAIL ovf_count k=%0d got=%0d exp=%0d", k, ovfs[k], k); end
      if (flat[k][32 +: 16] !== 16'h2222) begin failures++; $display("FAIL ovf_word2 k=%0d got=%h exp=2222", k, flat[k][32 +: 16]); end
    end
  endtask

  task automatic test_reset_mid();
    fab_req = 1; fab_we = 1; fab_addr = 7; fab_wdata = 16'hBEEF;
    host_cs = 0; host_we = 0; host_oe = 1; host_addr = 3; host_wdata = 16'h5555;
    step();
    #2 rst_n = 0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        checks += 2;
        if (gnt[k] !== 0 || h_rv[k] !== 0 || f_rv[k] !== 0) begin failures++; $display("FAIL rstmid_pulses k=%0d got=%b%b%b exp=000", k, gnt[k], h_rv[k], f_rv[k]); end
        if (flat[k] !== '0) begin failures++; $display("FAIL rstmid_flat k=%0d got=%h exp=0", k, flat[k]); end
      end
    end
    fab_req = 0; host_cs = 1; host_we = 1;
    rst_n = 1;
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (flat[k] !== '0 || h_rv[k] !== 0 || drop[k] !== 0) begin failures++; $display("FAIL rstmid_after k=%0d got=%h rv=%b exp=0", k, flat[k], h_rv[k]); end
    end
    host_cs = 0; host_we = 0; host_addr = 0; host_wdata = 16'hA5A5;
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (flat[k] !== {240'h0, 16'hA5A5}) begin failures++; $display("FAIL rstmid_rewrite k=%0d got=%h exp=a5a5", k, flat[k]); end
    end
    host_cs = 1; host_we = 1;
    step();
  endtask

  task automatic test_random();
    bit g0;
    for (int i = 0; i < 400; i++) begin
      host_cs = ($urandom_range(0, 3) == 0); host_we = $urandom_range(0, 1); host_oe = $urandom_range(0, 1);
      host_addr = 4'($urandom); host_wdata = 16'($urandom);
      if (!fab_req || $urandom_range(0, 7) == 0) begin
        fab_req = $urandom_range(0, 1); fab_we = $urandom_range(0, 1);
        fab_addr = 4'($urandom); fab_wdata = 16'($urandom);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (gnt[k] !== exp_gnt(k)) begin failures++; $display("FAIL rnd_gnt k=%0d cyc=%0d got=%b exp=%b", k, i, gnt[k], exp_gnt(k)); end
      end
      g0 = exp_gnt(0);
      step();
      for (int k = 0; k < 2; k++) begin
        checks += 4;
        if (flat[k] !== exp_flat(k)) begin failures++; $display("FAIL rnd_flat k=%0d cyc=%0d got=%h exp=%h", k, i, flat[k], exp_flat(k)); end
        if (h_rv[k] !== e_rv[k] || h_rdata[k] !== 16'(e_rdata[k])) begin failures++; $display("FAIL rnd_host_rd k=%0d cyc=%0d got=%b/%h exp=%b/%h", k, i, h_rv[k], h_rdata[k], e_rv[k], 16'(e_rdata[k])); end
        if (f_rv[k] !== e_frv[k] || f_rdata[k] !== 16'(e_frdata[k])) begin failures++; $display("FAIL rnd_fab_rd k=%0d cyc=%0d got=%b/%h exp=%b/%h", k, i, f_rv[k], f_rdata[k], e_frv[k], 16'(e_frdata[k])); end
        if (drop[k] !== e_drop[k] || ovf[k] !== e_ovf[k]) begin failures++; $display("FAIL rnd_pulses k=%0d cyc=%0d got=%b%b exp=%b%b", k, i, drop[k], ovf[k], e_drop[k], e_ovf[k]); end
      end
      if (g0) fab_req = 0;
    end
    fab_req = 0; host_cs = 1;
    step();
  endtask

  initial begin
    test_reset();
    test_host_write();
    test_ro_write();
    test_host_read();
    test_back_to_back();
    test_ovf();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
